// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite slave backed by a word memory with programmable wait states
`timescale 1ns/1ps
module ahb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [15:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic accept;
  logic legal;
  logic can_accept;
  logic unused_htrans;

  // htrans[0] only separates NONSEQ/SEQ and IDLE/BUSY, which behave alike here
  assign unused_htrans = htrans[0];
  assign accept = hsel & htrans[1] & hready_in;
  assign legal  = (haddr[15:8] == 8'h00) && (haddr[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    mem_d      = mem_q;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    hrdata     = 32'h0;
    can_accept = 1'b0;

    case (state_q)
      ST_IDLE: can_accept = 1'b1;
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 3'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_DONE: begin
        can_accept = 1'b1;
        if (write_q) mem_d[idx_q] = hwdata;
        else         hrdata       = mem_q[idx_q];
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp      = 1'b1;
        can_accept = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion cycles double as the address phase of the next transfer
    if (can_accept) begin
      if (accept) begin
        idx_d   = haddr[7:2];
        write_d = hwrite;
        cnt_d   = 3'd0;
        if (!legal) begin
          state_d = ST_ERR1;
        end else if (WAIT_CYCLES == 0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= 6'd0;
      write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - directed scoreboard bench for ahb_slave_mem at 0, 1 and 3 wait states
`timescale 1ns/1ps
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel_v;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready_in;

  logic [31:0] rdata_w0, rdata_w1, rdata_w3;
  logic        rdy_w0, rdy_w1, rdy_w3;
  logic        resp_w0, resp_w1, resp_w3;

  int          sel;
  logic [31:0] cur_rdata;
  logic        cur_rdy;
  logic        cur_resp;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata_w0), .hreadyout(rdy_w0), .hresp(resp_w0)
  );

  ahb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata_w1), .hreadyout(rdy_w1), .hresp(resp_w1)
  );

  ahb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready_in),
    .hrdata(rdata_w3), .hreadyout(rdy_w3), .hresp(resp_w3)
  );

  always_comb begin
    cur_rdata = rdata_w0;
    cur_rdy   = rdy_w0;
    cur_resp  = resp_w0;
    case (sel)
      1: begin cur_rdata = rdata_w1; cur_rdy = rdy_w1; cur_resp = resp_w1; end
      2: begin cur_rdata = rdata_w3; cur_rdy = rdy_w3; cur_resp = resp_w3; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic w);
    hsel_v      = 3'b000;
    hsel_v[sel] = 1'b1;
    htrans      = 2'b10;
    haddr       = a;
    hwrite      = w;
    hready_in   = 1'b1;
  endtask

  task automatic idle_bus();
    hsel_v = 3'b000;
    htrans = 2'b00;
  endtask

  // Walks the data phase until hreadyout rises, then pops and compares the oldest expectation
  task automatic complete(input string tag);
    exp_t e;
    int   waits = 0;
    bit   done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cur_rdy) begin
        done = 1'b1;
      end else begin
        if (sb_q.size() != 0) chk({tag, "_wait_resp"}, {31'd0, cur_resp}, {31'd0, sb_q[0].resp});
        waits++;
        haddr = 16'hFFFF;
        tick();
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_sb_nonempty"}, (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_waits"}, waits, e.waits);
      chk({tag, "_resp"}, {31'd0, cur_resp}, {31'd0, e.resp});
      chk({tag, "_rdata"}, cur_rdata, e.rdata);
    end
  endtask

  task automatic xfer(input string tag, input logic [15:0] a, input logic w, input logic [31:0] d,
                      input logic exp_resp, input logic [31:0] exp_rdata, input int exp_waits);
    addr_phase(a, w);
    sb_q.push_back('{exp_resp, exp_rdata, exp_waits});
    tick();
    idle_bus();
    hwdata = d;
    complete(tag);
    tick();
    chk({tag, "_idle_rdy"}, {31'd0, cur_rdy}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    hsel_v    = 3'b000;
    haddr     = 16'h0;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    hwdata    = 32'h0;
    hready_in = 1'b1;
    sel       = 0;

    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_rdy", {31'd0, cur_rdy}, 32'd1);
      chk("reset_resp", {31'd0, cur_resp}, 32'd0);
      chk("reset_rdata", cur_rdata, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();

    // One wait state: write then read back
    sel = 1;
    xfer("w1_wr", 16'h0010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    xfer("w1_rd", 16'h0010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1);

    // Illegal accesses produce the two-cycle ERROR and never write word 0
    xfer("err_hi", 16'h0100, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0, 1);
    xfer("err_mis", 16'h0002, 1'b1, 32'h0BADBEEF, 1'b1, 32'h0, 1);
    xfer("rd_word0", 16'h0000, 1'b0, 32'h0, 1'b0, 32'h0, 1);

    // Inactive transfers: IDLE htrans with hsel, and active htrans without hsel
    hsel_v = 3'b010;
    htrans = 2'b00;
    haddr  = 16'h0010;
    hwrite = 1'b1;
    tick();
    hwdata = 32'hFFFFFFFF;
    chk("idle_trans_rdy", {31'd0, cur_rdy}, 32'd1);
    chk("idle_trans_resp", {31'd0, cur_resp}, 32'd0);
    hsel_v = 3'b000;
    htrans = 2'b10;
    tick();
    chk("nosel_rdy", {31'd0, cur_rdy}, 32'd1);
    chk("nosel_resp", {31'd0, cur_resp}, 32'd0);
    idle_bus();
    tick();
    xfer("rd_unchanged", 16'h0010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1);

    // hready_in low blocks the accept; the same request then goes through
    addr_phase(16'h0010, 1'b0);
    hready_in = 1'b0;
    tick();
    chk("hready_low_rdy", {31'd0, cur_rdy}, 32'd1);
    chk("hready_low_rdata", cur_rdata, 32'h0);
    hready_in = 1'b1;
    xfer("hready_retry", 16'h0010, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1);

    // Zero wait states: pipelined write followed directly by a read of the same word
    sel = 0;
    addr_phase(16'h0004, 1'b1);
    sb_q.push_back('{1'b0, 32'h0, 0});
    tick();
    addr_phase(16'h0004, 1'b0);
    sb_q.push_back('{1'b0, 32'h12345678, 0});
    hwdata = 32'h12345678;
    complete("b2b_wr");
    tick();
    idle_bus();
    hwdata = 32'h0;
    complete("b2b_rd");
    tick();
    chk("b2b_idle_rdy", {31'd0, cur_rdy}, 32'd1);
    chk("b2b_idle_rdata", cur_rdata, 32'h0);

    // Three wait states: normal round trip, then reset in the middle of a write
    sel = 2;
    xfer("w3_wr", 16'h0008, 1'b1, 32'h11111111, 1'b0, 32'h0, 3);
    xfer("w3_rd", 16'h0008, 1'b0, 32'h0, 1'b0, 32'h11111111, 3);
    addr_phase(16'h0008, 1'b1);
    tick();
    idle_bus();
    hwdata = 32'hA5A5A5A5;
    chk("abort_wait1_rdy", {31'd0, cur_rdy}, 32'd0);
    tick();
    chk("abort_wait2_rdy", {31'd0, cur_rdy}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_async_rdy", {31'd0, cur_rdy}, 32'd1);
    chk("abort_async_resp", {31'd0, cur_resp}, 32'd0);
    chk("abort_async_rdata", cur_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    xfer("w3_rd_after_rst", 16'h0008, 1'b0, 32'h0, 1'b0, 32'h0, 3);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- DEPTH, 64, number of 32-bit words; word index = haddr[7:2].
- WAIT_CYCLES, 1, wait states inserted before each OKAY completion; legal range 0..7.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select from the address decoder.
- haddr  in  16  transfer address.
- htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ (active), clear = IDLE/BUSY.
- hwrite  in  1  1 = write, 0 = read.
- hwdata  in  32  write data, valid in the data phase.
- hready_in  in  1  bus-level ready; high = the previous data phase is ending.
- hrdata  out  32  read data.
- hreadyout  out  1  slave ready; low = extend the data phase.
- hresp  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-003 An address phase SHALL be accepted at a rising edge only when hsel=1, htrans[1]=1 and hready_in=1; it captures haddr and hwrite.
REQ-004 The accepted address SHALL be legal only if haddr[15:8]=0 and haddr[1:0]=0; otherwise the transfer is an error transfer.
REQ-005 The FSM SHALL use the states IDLE, WAIT, DONE, ERR1 and ERR2.
REQ-006 From IDLE or DONE, the next state on accept SHALL be:
- ERR1 if the address is illegal;
- DONE if WAIT_CYCLES=0;
- WAIT otherwise, with the wait counter loaded to WAIT_CYCLES-1.
REQ-007 From IDLE or DONE with no accept, the next state SHALL be IDLE.
REQ-008 In WAIT, hreadyout SHALL be 0 and hresp 0; the counter decrements each cycle, and the FSM moves to DONE after the cycle in which the counter is 0.
REQ-009 In DONE, hreadyout SHALL be 1 and hresp 0; this is the completion cycle.
REQ-010 A write SHALL update mem[haddr[7:2]] with hwdata at the rising edge that ends DONE.
REQ-011 A read SHALL drive hrdata = mem[captured index] combinationally during DONE; at all other times hrdata SHALL be 32'h0.
REQ-012 In ERR1, outputs SHALL be hresp=1, hreadyout=0; the FSM then moves unconditionally to ERR2.
REQ-013 In ERR2, outputs SHALL be hresp=1, hreadyout=1; the FSM accepts a new address phase per REQ-006, else goes to IDLE; memory is never written by an error transfer.
REQ-014 In IDLE, outputs SHALL be hreadyout=1, hresp=0; IDLE/BUSY transfers, and transfers with hsel=0, get a zero-wait OKAY with no state change.
REQ-015 Back-to-back transfers SHALL be pipelined: an address phase presented during DONE or ERR2 is accepted at the same edge that ends that cycle.
REQ-016 A read whose data phase directly follows a write to the same word SHALL return the newly written data.
REQ-017 Changes on hsel, htrans or haddr during WAIT or ERR1 SHALL be ignored; the in-flight transfer completes unchanged.
REQ-018 While hready_in=0 and the block is in IDLE, no address phase SHALL be accepted.

Reset
REQ-019 While rst=0, regardless of clk, the block SHALL force:
- state IDLE and wait counter 0;
- hreadyout=1, hresp=0, hrdata=32'h0;
- all memory words to 32'h0.
REQ-020 A reset asserted mid-transfer (WAIT, DONE, ERR1 or ERR2) SHALL abandon the transfer without writing memory; the first accept after rst rises is handled normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- WAIT_CYCLES=1: write 32'hDEADBEEF to haddr 16'h0010, then read 16'h0010 -> one cycle hreadyout=0, then DONE; the read completion cycle shows hrdata=32'hDEADBEEF, hresp=0.
- WAIT_CYCLES=0: back-to-back write 32'h12345678 @ 16'h0004 then read @ 16'h0004 -> hreadyout constantly 1, and the read data phase shows 32'h12345678 (REQ-016).
- Illegal accesses @ 16'h0100 and @ 16'h0002 -> each gives ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1); a following read of word 0 returns 32'h0 (no write occurred).
- htrans=2'b00 with hsel=1, and htrans=2'b10 with hsel=0 -> state stays IDLE, hreadyout=1, hresp=0, memory unchanged.
- WAIT_CYCLES=3: rst=0 pulsed during the second WAIT cycle of a write 32'hA5A5A5A5 @ 16'h0008 -> hreadyout=1 immediately (asynchronously); a later read of 16'h0008 returns 32'h0.
- Accept attempt with hready_in=0 in IDLE -> ignored; the same request repeated with hready_in=1 -> accepted.
